// File: rtl/sseg_mux_driver.sv
// ----------------------------------------------------------------------------
// sseg_mux_driver
//
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// The datapath loads hex nibbles, decimal points and per-digit enables into
// a shadow set. The shadow set is copied into the displayed (active) set only
// at a frame boundary, so a scan never shows a mix of old and new digits.
// Exactly one digit is lit per scan slot. A slot lasts PRESCALE clocks.
//
// Parameters:
//   N_DIGITS  number of scanned digits (1..8)
//   PRESCALE  clocks per scan slot (>= 2)
//   DEADTIME  blanking clocks at the start of each slot (< PRESCALE);
//             used only when the optional feature is built in
//
// Optional feature macro: SSEG_DEADTIME_EN
//   When defined, the first DEADTIME clocks of every slot are driven blank
//   to stop ghosting while the anode drivers switch. When undefined, no
//   blanking logic exists and DEADTIME has no effect.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high; has priority over all inputs
//   load        in   single-cycle strobe; captures hex_in/dp_in/digit_en
//   hex_in      in   [4*N_DIGITS]; digit k is bits [4k+3:4k]; digit 0 is
//                    the rightmost digit
//   dp_in       in   [N_DIGITS]; decimal point request, 1 = lit
//   digit_en    in   [N_DIGITS]; 1 = digit shown, 0 = digit blanked
//   an          out  [N_DIGITS]; anode selects, active-low, registered
//   sseg        out  [7]; segments gfedcba, active-low, registered
//   dp          out  decimal point segment, active-low, registered
//   frame_tick  out  one-cycle pulse in the cycle after each frame boundary
//
// Load handshake: load has no ready. Every cycle with load = 1 is accepted
// and overwrites the shadow set, so the last load before a frame boundary
// wins. If load = 1 on the boundary cycle itself, the inputs go straight to
// the active set and nothing is left pending.
// ----------------------------------------------------------------------------
module sseg_mux_driver #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned DEADTIME = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              sseg,
    output logic                    dp,
    output logic                    frame_tick
);

    // ------------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------------
    // The prescaler is sized to hold the larger of PRESCALE-1 and DEADTIME.
    // The dead-time compare can then never truncate its constant, even when
    // DEADTIME is illegally large.
    localparam int unsigned CNT_SPAN = (DEADTIME >= PRESCALE) ? DEADTIME + 1 : PRESCALE;
    localparam int unsigned PW       = $clog2(CNT_SPAN);
    localparam int unsigned IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0]           prescale_q, prescale_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    pending_q, pending_d;

    logic [4*N_DIGITS-1:0]   shadow_hex_q, shadow_hex_d;
    logic [N_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [N_DIGITS-1:0]     shadow_en_q, shadow_en_d;

    logic [4*N_DIGITS-1:0]   active_hex_q, active_hex_d;
    logic [N_DIGITS-1:0]     active_dp_q, active_dp_d;
    logic [N_DIGITS-1:0]     active_en_q, active_en_d;

    logic [N_DIGITS-1:0]     an_q, an_d;
    logic [6:0]              sseg_q, sseg_d;
    logic                    dp_q, dp_d;
    logic                    frame_tick_q, frame_tick_d;

    // Scan timing decodes
    logic                    slot_end;
    logic                    frame_end;

    // Digit currently addressed by idx_q, taken from the active set
    logic [3:0]              sel_hex;
    logic                    sel_dp;
    logic                    sel_en;
    logic [N_DIGITS-1:0]     sel_an_n;
    logic                    drive;

    // ------------------------------------------------------------------------
    // Hex to active-low gfedcba segment pattern
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b1111111;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------------
    always_comb begin
        slot_end   = (prescale_q == PS_LAST);
        frame_end  = slot_end && (idx_q == IDX_LAST);

        prescale_d = prescale_q + PW'(1);
        idx_d      = idx_q;
        if (slot_end) begin
            prescale_d = '0;
            // With a single digit IDX_LAST is 0, so the index stays at 0.
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shadow / active data sets
    // ------------------------------------------------------------------------
    always_comb begin
        shadow_hex_d = shadow_hex_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_en_d  = shadow_en_q;
        active_hex_d = active_hex_q;
        active_dp_d  = active_dp_q;
        active_en_d  = active_en_q;
        pending_d    = pending_q;

        if (load) begin
            shadow_hex_d = hex_in;
            shadow_dp_d  = dp_in;
            shadow_en_d  = digit_en;
            pending_d    = 1'b1;
        end

        if (frame_end) begin
            // A load on the boundary cycle is newer than anything held in
            // the shadow set, so it goes straight to the active set.
            pending_d = 1'b0;
            if (load) begin
                active_hex_d = hex_in;
                active_dp_d  = dp_in;
                active_en_d  = digit_en;
            end else if (pending_q) begin
                active_hex_d = shadow_hex_q;
                active_dp_d  = shadow_dp_q;
                active_en_d  = shadow_en_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output drive (registered one cycle after index/active)
    // ------------------------------------------------------------------------
    always_comb begin
        sel_hex  = '0;
        sel_dp   = 1'b0;
        sel_en   = 1'b0;
        sel_an_n = '1;
        // An explicit compare per digit keeps every select in range, even
        // when N_DIGITS is not a power of two.
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                sel_hex     = active_hex_q[4*k +: 4];
                sel_dp      = active_dp_q[k];
                sel_en      = active_en_q[k];
                sel_an_n[k] = 1'b0;
            end
        end

        drive = sel_en;
`ifdef SSEG_DEADTIME_EN
        // Blank the start of each slot while the anode drivers switch.
        if (prescale_q < PW'(DEADTIME)) begin
            drive = 1'b0;
        end
`endif

        an_d   = '1;
        sseg_d = 7'b1111111;
        dp_d   = 1'b1;
        if (drive) begin
            an_d   = sel_an_n;
            sseg_d = seg_decode(sel_hex);
            dp_d   = ~sel_dp;
        end

        frame_tick_d = frame_end;
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q   <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            shadow_hex_q <= '0;
            shadow_dp_q  <= '0;
            shadow_en_q  <= '0;
            active_hex_q <= '0;
            active_dp_q  <= '0;
            active_en_q  <= '0;
            an_q         <= '1;
            sseg_q       <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            prescale_q   <= prescale_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_hex_q <= shadow_hex_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_en_q  <= shadow_en_d;
            active_hex_q <= active_hex_d;
            active_dp_q  <= active_dp_d;
            active_en_q  <= active_en_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
